cache_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single cache controller between N_REQ requesters (e.g. instruction fetch and data port). It picks one pending request, issues a one-cycle Run pulse with RW/address/write-data to the cache controller, and waits for completion or a timeout. It then returns a one-cycle done, with read data and an error flag, to the granted requester. Sits between the requester ports and the cache controller.

---
 rtl/cache_pkg.sv | 16 +
 rtl/rr_pick.sv | 38 +++
 rtl/cache_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache-side definitions.
// Holds the request-arbiter FSM state type and the RW op encoding.
// The cache controller FSM uses the same RW encoding.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
// Ports:
//   req : request vector
//   ptr : index holding top priority
//   gnt : one-hot winner, all zero when nothing is requested
//   vld : at least one request is set
// The winner is the first set bit at or above ptr, wrapping to bit 0.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             vld
);

  // First pass covers bits at or above ptr. The second pass covers the wrapped
  // region. Because the first pass has priority, the wrapped bits only win
  // when nothing at or above ptr is set.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!vld && req[j] && (j >= int'(ptr))) begin
        gnt[j] = 1'b1;
        vld    = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!vld && req[j]) begin
        gnt[j] = 1'b1;
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter and sequencer in front of the single cache controller.
// Ports:
//   clk, reset                   : clock; asynchronous active-low reset
//   req/rw/addr/wdata            : requester ports; req held until its done
//   grant                        : one-hot owner; 0 when idle
//   done                         : one-cycle completion pulse to the owner
//   err                          : timeout flag, valid with done
//   rdata                        : read data, valid with done
//   busy                         : FSM not in IDLE
//   cache_run                    : one-cycle start pulse to the controller
//   cache_rw/cache_addr/
//   cache_wdata                  : operation latched at grant time
//   cache_done/cache_rdata       : controller completion and read data
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0]               rw,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]               grant,
  output logic [N_REQ-1:0]               done,
  output logic                           err,
  output logic [DATA_W-1:0]              rdata,
  output logic                           busy,
  output logic                           cache_run,
  output logic                           cache_rw,
  output logic [ADDR_W-1:0]              cache_addr,
  output logic [DATA_W-1:0]              cache_wdata,
  input  logic                           cache_done,
  input  logic [DATA_W-1:0]              cache_rdata
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t          state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gidx;
  logic [CW-1:0]       cnt;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [N_REQ-1:0]    pick_gnt;
  logic                pick_vld;
  logic [PW-1:0]       pick_idx;
  logic                pick_rw;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  // Select the winner's operation with a one-hot mux.
  always_comb begin
    pick_idx   = '0;
    pick_rw    = RW_READ;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick_gnt[j]) begin
        pick_idx   = PW'(j);
        pick_rw    = rw[j];
        pick_addr  = addr[j];
        pick_wdata = wdata[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      gidx        <= '0;
      cnt         <= '0;
      grant       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cache_rw    <= RW_READ;
      cache_addr  <= '0;
      cache_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant       <= pick_gnt;
            gidx        <= pick_idx;
            cache_rw    <= pick_rw;
            cache_addr  <= pick_addr;
            cache_wdata <= pick_wdata;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // When completion and timeout fall in the same cycle, completion wins.
          if (cache_done) begin
            rdata_q <= (cache_rw == RW_WRITE) ? '0 : cache_rdata;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ptr     <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
          grant   <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done      = (state == RESP) ? grant : '0;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state != IDLE);
  assign cache_run = (state == ISSUE);

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: directed scenarios plus random
// traffic, checked against a transaction-level round-robin model.
module tb_cache_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req, rw, grant, done;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic                 err, busy, cache_run, cache_rw, cache_done;
  logic [DW-1:0]        rdata, cache_wdata, cache_rdata;
  logic [AW-1:0]        cache_addr;

  cache_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .grant(grant), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .cache_run(cache_run), .cache_rw(cache_rw), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_done(cache_done), .cache_rdata(cache_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ptr_m = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observations from the most recent transaction.
  logic [N-1:0]  o_grant, o_done, o_done_after;
  logic          o_rw, o_err, o_busy_after;
  logic [AW-1:0] o_addr, o_addr_end;
  logic [DW-1:0] o_wdata, o_rdata;
  int            o_delay, o_runs;
  bit            o_ok;

  // Reference: first set request searching upward from ptr, modulo N.
  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Drives the cache side of one transaction. lat = WAIT cycles before
  // cache_done (lat >= TO means never). Entered and left at #1 after an edge.
  task automatic do_txn(input int lat, input logic [DW-1:0] rd, input bit scramble);
    int t_run;
    bit seen;
    o_ok = 0; o_runs = 0; seen = 0; t_run = 0; o_delay = -1;
    o_grant = 'x; o_done = '0; o_err = 1'bx; o_rdata = 'x; o_addr_end = 'x;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (cache_run) begin
        seen = 1; o_runs = 1; t_run = cyc;
        o_grant = grant; o_rw = cache_rw; o_addr = cache_addr; o_wdata = cache_wdata;
      end
    end
    if (!seen) return;
    @(posedge clk); #1;
    for (int w = 0; w < 3 * TO; w++) begin
      cache_done  = (w == lat);
      cache_rdata = (w == lat) ? rd : DW'($urandom);
      if (scramble && w == 0) begin
        for (int i = 0; i < N; i++) begin
          addr[i]  = addr[i] ^ 32'h300;
          wdata[i] = wdata[i] ^ 32'hFFFF;
        end
        rw = ~rw;
      end
      @(posedge clk); #1;
      cache_done = 1'b0;
      if (cache_run) o_runs++;
      if (done != '0) begin
        o_done = done; o_err = err; o_rdata = rdata; o_addr_end = cache_addr;
        o_delay = cyc - t_run; o_ok = 1;
        break;
      end
    end
    if (!o_ok) return;
    @(posedge clk); #1;
    o_done_after = done; o_busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; rw = '0; addr = '0; wdata = '0;
    cache_done = 1'b0; cache_rdata = '0;
    #12;
    checks++;
    if ({grant, done, err, rdata, busy, cache_run, cache_rw, cache_addr, cache_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got grant=%b done=%b err=%b rdata=%h busy=%b run=%b rw=%b addr=%h wdata=%h required all 0",
                         grant, done, err, rdata, busy, cache_run, cache_rw, cache_addr, cache_wdata);
    end
    @(posedge clk); #1; reset = 1'b1; ptr_m = 0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_single_read();
    req = 2'b01; rw = 2'b00; addr[0] = 32'h100;
    do_txn(0, 32'hDEADBEEF, 0);
    checks++; if (!o_ok) begin errors++; $display("FAIL single_complete: got none required done"); end
    checks++; if (o_runs != 1) begin errors++; $display("FAIL single_runs: got %0d required 1", o_runs); end
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL single_addr: got %h required 100", o_addr); end
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL single_rw: got %b required 0", o_rw); end
    checks++; if (o_done !== 2'b01) begin errors++; $display("FAIL single_done: got %b required 01", o_done); end
    checks++; if (o_delay != 2) begin errors++; $display("FAIL single_latency: got %0d required 2", o_delay); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h required deadbeef", o_rdata); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b required 0", o_err); end
    checks++; if (o_done_after !== '0) begin errors++; $display("FAIL single_done_pulse: got %b required 00", o_done_after); end
    req = '0; ptr_m = 1;
  endtask

  task automatic test_fairness();
    int w;
    req = 2'b11; rw = 2'b00; addr[0] = 32'hA0; addr[1] = 32'hB1;
    for (int t = 0; t < 4; t++) begin
      w = rr_model(req, ptr_m);
      do_txn(0, DW'(t), 0);
      checks++; if (o_grant !== onehot(w)) begin errors++; $display("FAIL fair_grant%0d: got %b required %b", t, o_grant, onehot(w)); end
      checks++; if (o_addr !== addr[w]) begin errors++; $display("FAIL fair_addr%0d: got %h required %h", t, o_addr, addr[w]); end
      ptr_m = (w + 1) % N;
    end
    req = '0;
  endtask

  task automatic test_timeout();
    req = 2'b10; rw = 2'b10; wdata[1] = 32'h55AA; addr[1] = 32'h44;
    do_txn(1000, 32'h1234, 0);
    checks++; if (o_done !== 2'b10) begin errors++; $display("FAIL to_done: got %b required 10", o_done); end
    checks++; if (o_delay != TO + 1) begin errors++; $display("FAIL to_latency: got %0d required %0d", o_delay, TO + 1); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b required 1", o_err); end
    checks++; if (o_rdata !== '0) begin errors++; $display("FAIL to_rdata: got %h required 0", o_rdata); end
    checks++; if (o_wdata !== 32'h55AA || o_rw !== 1'b1) begin errors++; $display("FAIL to_op: got rw=%b wdata=%h required 1/55aa", o_rw, o_wdata); end
    checks++; if (o_busy_after !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b required 0", o_busy_after); end
    ptr_m = 0;
    // Completion on the last allowed cycle beats the timeout.
    rw = 2'b00;
    do_txn(TO - 1, 32'hCAFE0001, 0);
    checks++; if (o_err !== 1'b0 || o_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL tie_done_wins: got err=%b rdata=%h required 0/cafe0001", o_err, o_rdata); end
    checks++; if (o_delay != TO + 1) begin errors++; $display("FAIL tie_latency: got %0d required %0d", o_delay, TO + 1); end
    req = '0; ptr_m = 0;
  endtask

  task automatic test_early_done();
    int n_done, dw;
    n_done = 0; dw = -1;
    req = '0; cache_done = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++; if (done !== '0 || busy !== 1'b0) begin errors++; $display("FAIL early_idle: got done=%b busy=%b required 00/0", done, busy); end
    req = 2'b01; rw = 2'b00; addr[0] = 32'h77;
    @(posedge clk); #1;
    checks++; if (cache_run !== 1'b1) begin errors++; $display("FAIL early_issue: got run=%b required 1", cache_run); end
    @(posedge clk); #1;
    checks++; if (done !== '0 || busy !== 1'b1) begin errors++; $display("FAIL early_issue_ignored: got done=%b busy=%b required 00/1", done, busy); end
    for (int w = 0; w < 20; w++) begin
      cache_done = (w == 2); cache_rdata = 32'h0BADF00D;
      @(posedge clk); #1;
      cache_done = 1'b0;
      if (done != '0) begin n_done++; dw = w; req = '0; end
    end
    checks++; if (n_done != 1 || dw != 2) begin errors++; $display("FAIL early_one_done: got count=%0d at=%0d required 1 at 2", n_done, dw); end
    ptr_m = 1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    req = 2'b10; rw = 2'b10; addr[1] = 32'hFACE; wdata[1] = 32'h9;
    for (int k = 0; k < 10 && !seen; k++) begin @(posedge clk); #1; seen = cache_run; end
    @(posedge clk); #1; @(posedge clk); #1;
    checks++; if (!seen || busy !== 1'b1) begin errors++; $display("FAIL rst_setup: got run_seen=%0d busy=%b required 1/1", seen, busy); end
    #2; reset = 1'b0; req = 2'b11; #1;
    checks++;
    if ({grant, done, err, rdata, busy, cache_run, cache_rw, cache_addr, cache_wdata} !== '0) begin
      errors++; $display("FAIL rst_async: got grant=%b done=%b busy=%b run=%b rw=%b addr=%h required all 0",
                         grant, done, busy, cache_run, cache_rw, cache_addr);
    end
    @(posedge clk); #1;
    checks++; if (done !== '0) begin errors++; $display("FAIL rst_no_done: got %b required 00", done); end
    reset = 1'b1; ptr_m = 0;
    do_txn(0, 32'h5, 0);
    checks++; if (o_grant !== onehot(rr_model(req, ptr_m))) begin errors++; $display("FAIL rst_ptr0: got %b required %b", o_grant, onehot(rr_model(req, ptr_m))); end
    req[0] = 1'b0; ptr_m = 1;
    do_txn(0, 32'h6, 0);
    checks++; if (o_grant !== 2'b10) begin errors++; $display("FAIL rst_next: got %b required 10", o_grant); end
    req = '0; ptr_m = 0;
  endtask

  task automatic test_addr_change();
    req = 2'b01; rw = 2'b00; addr[0] = 32'h100;
    do_txn(3, 32'h600D, 1);
    checks++; if (addr[0] !== 32'h200) begin errors++; $display("FAIL chg_setup: got %h required 200", addr[0]); end
    checks++; if (o_addr_end !== 32'h100) begin errors++; $display("FAIL chg_latched_addr: got %h required 100", o_addr_end); end
    checks++; if (o_rdata !== 32'h600D || o_err !== 1'b0) begin errors++; $display("FAIL chg_rdata: got %h err=%b required 600d/0", o_rdata, o_err); end
    req = '0; ptr_m = 1;
  endtask

  task automatic test_random();
    int w, lat;
    logic e_rw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, rd, e_rdata;
    bit scr;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1; rw[i] = 1'($urandom_range(0, 1));
          addr[i] = AW'($urandom); wdata[i] = DW'($urandom);
        end
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
      w = rr_model(req, ptr_m);
      e_rw = rw[w]; e_addr = addr[w]; e_wdata = wdata[w];
      lat = int'($urandom_range(0, TO + 1));
      rd = DW'($urandom);
      scr = 1'($urandom_range(0, 1));
      e_rdata = (lat < TO && e_rw == 1'b0) ? rd : '0;
      do_txn(lat, rd, scr);
      checks++; if (o_grant !== onehot(w) || o_done !== onehot(w)) begin errors++; $display("FAIL rand_grant%0d: got grant=%b done=%b required %b", t, o_grant, o_done, onehot(w)); end
      checks++; if (o_rw !== e_rw || o_addr !== e_addr || o_wdata !== e_wdata || o_addr_end !== e_addr) begin
        errors++; $display("FAIL rand_op%0d: got rw=%b addr=%h/%h wdata=%h required %b %h %h", t, o_rw, o_addr, o_addr_end, o_wdata, e_rw, e_addr, e_wdata);
      end
      checks++; if (o_delay != ((lat < TO) ? lat + 2 : TO + 1)) begin errors++; $display("FAIL rand_latency%0d: got %0d required %0d", t, o_delay, (lat < TO) ? lat + 2 : TO + 1); end
      checks++; if (o_err !== (lat >= TO) || o_rdata !== e_rdata) begin errors++; $display("FAIL rand_resp%0d: got err=%b rdata=%h required %b %h", t, o_err, o_rdata, lat >= TO, e_rdata); end
      checks++; if (o_runs != 1 || o_done_after !== '0) begin errors++; $display("FAIL rand_pulses%0d: got runs=%0d done_after=%b required 1/00", t, o_runs, o_done_after); end
      req[w] = 1'b0;
      ptr_m = (w + 1) % N;
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_timeout();
    test_early_done();
    test_reset_mid();
    test_addr_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
